// File: rtl/data_mem_responder.sv
// Fixed-latency 16-bit word memory responder for the MEM stage.
// Requests are latched on acceptance and completed LATENCY cycles later.
module data_mem_responder #(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [3:0]             cnt_d;
  logic                   wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [ADDR_BITS-1:0]   idx_d;
  logic [15:0]            wdata_q;
  logic [1:0]             be_q;
  logic                   resp_q;
  logic                   busy_q;
  logic [15:0]            rdata_q;
  logic [15:0]            mem_q [2**ADDR_BITS];
  logic                   unused_addr_bits;

  // Byte offset and bits above the array size alias onto the same word.
  assign idx_d            = mem_address[ADDR_BITS:1];
  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};
  assign cnt_d            = cnt_q - 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (mem_read || mem_write) begin
            wr_q    <= mem_write;
            idx_q   <= idx_d;
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= DONE;
              cnt_q   <= '0;
              resp_q  <= 1'b1;
              if (!mem_write) rdata_q <= mem_q[idx_d];
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_d;
          // Read data is captured on entry so it is valid throughout DONE.
          if (cnt_d == '0) begin
            state_q <= DONE;
            resp_q  <= 1'b1;
            if (!wr_q) rdata_q <= mem_q[idx_q];
          end
        end
        DONE: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array is not reset; a reset during DONE suppresses the write.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == DONE && wr_q) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, reset/back-to-back sequences,
// LATENCY=1 read+write collision, and randomized ops against a word-array model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        resp3, busy3;
  logic [15:0] rdata3;

  logic        rd1, wr1;
  logic [15:0] a1, wd1;
  logic [1:0]  be1;
  logic        resp1, busy1;
  logic [15:0] rdata1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mm [256];
  logic [15:0] m_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) u3 (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(resp3), .mem_rdata(rdata3), .busy(busy3));

  data_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u1 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd1), .mem_write(wr1),
    .mem_address(a1), .mem_wdata(wd1), .mem_byte_enable(be1),
    .mem_resp(resp1), .mem_rdata(rdata1), .busy(busy1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 256;
  endfunction

  // Called just after the acceptance edge; counts cycles until mem_resp.
  task automatic wait_resp(input string name, output logic [15:0] got);
    int n = 0;
    bit done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (resp3) done = 1;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_busy_done"}, busy3, 1'b1);
    got = rdata3;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_op(input string name, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                       output logic [15:0] got);
    @(negedge clk);
    check({name, "_idle_busy"}, busy3, 1'b0);
    check({name, "_idle_resp"}, resp3, 1'b0);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    @(posedge clk);
    wait_resp(name, got);
  endtask

  task automatic run_op(input string name, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] got);
    int i = widx(a);
    logic [15:0] exp;
    if (wr) begin
      exp = m_rdata;
      mm[i] = (be[0] ? (wd & 16'h00FF) : (mm[i] & 16'h00FF)) |
              (be[1] ? (wd & 16'hFF00) : (mm[i] & 16'hFF00));
    end else begin
      exp = mm[i];
      m_rdata = exp;
    end
    do_op(name, rd, wr, a, wd, be, got);
    check({name, "_rdata"}, got, exp);
  endtask

  task automatic op1(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be,
                     output logic [15:0] got, output int lat);
    bit done = 0;
    @(negedge clk);
    rd1 = rd; wr1 = wr; a1 = a; wd1 = wd; be1 = be;
    @(posedge clk);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (resp1) done = 1;
    end
    got = rdata1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int lat;

    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 1'b0, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b1, 16'hABCD};
    tbl[6] = '{1'b0, 1'b1, 16'h0004, 16'h5A5A, 2'b11, 1'b0, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 2'b01, 1'b1, 16'h5A5A};
    tbl[8] = '{1'b1, 1'b0, 16'h0204, 16'h0000, 2'b10, 1'b1, 16'h5A5A};

    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0; be1 = '0;
    m_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_resp", resp3, 1'b0);
    check("rst_busy", busy3, 1'b0);
    check("rst_rdata", rdata3, 16'h0000);
    check("rst_rdata_l1", rdata1, 16'h0000);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_op($sformatf("vec%0d", k), tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].wd, tbl[k].be, got);
      if (tbl[k].chk) check($sformatf("vec%0d_const", k), got, tbl[k].exp);
    end

    // Reset during BUSY aborts a write; a read held through reset is taken on release.
    run_op("pre_rst", 1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, got);
    @(negedge clk);
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy3, 1'b1);
    check("mid_resp", resp3, 1'b0);
    reset_n = 1'b0;
    mem_write = 1'b0; mem_read = 1'b1;
    @(negedge clk);
    check("abort_resp", resp3, 1'b0);
    check("abort_busy", busy3, 1'b0);
    check("abort_rdata", rdata3, 16'h0000);
    m_rdata = 16'h0000;
    reset_n = 1'b1;
    @(posedge clk);
    wait_resp("post_rst", got);
    m_rdata = mm[widx(16'h0030)];
    check("post_rst_rdata", got, m_rdata);
    check("post_rst_const", got, 16'h1111);

    // Continuous read: period LATENCY+1, busy low only in the acceptance cycle.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("b2b_resp%0d", k), resp3, (k % 4) == 3);
      check($sformatf("b2b_busy%0d", k), busy3, (k % 4) != 0);
      if (k == 11) begin
        m_rdata = mm[widx(16'h0010)];
        check("b2b_rdata", rdata3, m_rdata);
        mem_read = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    // LATENCY=1 instance: read+write collision behaves as a write.
    op1(1'b0, 1'b1, 16'h0008, 16'h7777, 2'b11, got, lat);
    check("l1_wr_lat", lat, 1);
    op1(1'b1, 1'b0, 16'h0008, 16'h0000, 2'b11, got, lat);
    check("l1_rd_lat", lat, 1);
    check("l1_rd_data", got, 16'h7777);
    op1(1'b1, 1'b1, 16'h0008, 16'h3C3C, 2'b11, got, lat);
    check("l1_both_lat", lat, 1);
    check("l1_both_rdata", got, 16'h7777);
    check("l1_both_busy", busy1, 1'b1);
    op1(1'b1, 1'b0, 16'h0008, 16'h0000, 2'b00, got, lat);
    check("l1_rd2_data", got, 16'h3C3C);

    for (int k = 0; k < 8; k++)
      run_op("rinit", 1'b0, 1'b1, 16'(16'h0080 + 2 * k), 16'($urandom), 2'b11, got);
    for (int k = 0; k < 40; k++) begin
      logic [15:0] a;
      int op;
      a  = {7'($urandom), 8'(8'h40 + $urandom_range(0, 7)), 1'($urandom)};
      op = $urandom_range(0, 2);
      run_op($sformatf("rnd%0d", k), op != 1, op != 0, a, 16'($urandom), 2'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
